// File: rtl/haz_pkg.sv
// Shared types for the hazard scoreboard: forwarding select encoding and the
// per-stage scoreboard entry.
package haz_pkg;

  localparam int SB_NREAD   = 2;
  localparam int SB_RADDR_W = 4;
  localparam logic [SB_RADDR_W-1:0] PC_IDX_DEF = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Field widths follow SB_NREAD/SB_RADDR_W; the top's parameters must agree.
  typedef struct packed {
    logic                                  v;
    logic                                  reg_write;
    logic                                  mem_to_reg;
    logic                                  pc_src;
    logic [SB_RADDR_W-1:0]                 wa3;
    logic [SB_NREAD-1:0][SB_RADDR_W-1:0]   ra;
    logic [SB_NREAD-1:0]                   use_ra;
  } sb_entry_t;

endpackage

// File: rtl/haz_port_fwd.sv
// One read port's view of the scoreboard: M/W forward select for the E-stage
// operand and the load-use hit for the D-stage operand.
module haz_port_fwd
  import haz_pkg::*;
#(
  parameter int                 RADDR_W = SB_RADDR_W,
  parameter logic [RADDR_W-1:0] PC_IDX  = PC_IDX_DEF
) (
  input  logic [RADDR_W-1:0] ra_e_i,
  input  logic               use_e_i,
  input  logic               wr_m_i,
  input  logic [RADDR_W-1:0] wa3_m_i,
  input  logic               wr_w_i,
  input  logic [RADDR_W-1:0] wa3_w_i,
  input  logic [RADDR_W-1:0] rad_i,
  input  logic               use_d_i,
  input  logic               ld_e_i,
  input  logic [RADDR_W-1:0] wa3_e_i,
  output fwd_sel_e           fwd_o,
  output logic               ld_hit_o
);

  // M is the younger writer, so it is checked first.
  always_comb begin
    fwd_o = FWD_RF;
    if (use_e_i && (ra_e_i != PC_IDX)) begin
      if (wr_m_i && (wa3_m_i == ra_e_i))      fwd_o = FWD_M;
      else if (wr_w_i && (wa3_w_i == ra_e_i)) fwd_o = FWD_W;
    end
  end

  assign ld_hit_o = use_d_i & ld_e_i & (wa3_e_i == rad_i) & (rad_i != PC_IDX);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit with its own E/M/W scoreboard of destination tags.
// Define HAZ_PERF_CNT_EN to add the StallCnt/FlushCnt performance counters.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int                 NREAD   = SB_NREAD,
  parameter int                 RADDR_W = SB_RADDR_W,
  parameter logic [RADDR_W-1:0] PC_IDX  = PC_IDX_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWriteD,
  input  logic                     MemtoRegD,
  input  logic                     PCSrcD,
  input  logic [RADDR_W-1:0]       WA3D,
  input  logic [NREAD*RADDR_W-1:0] RAD,
  input  logic [NREAD-1:0]         UseRAD,
  input  logic                     BranchTakenE,
  output logic [2*NREAD-1:0]       ForwardE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     PCSrcW
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]              StallCnt,
  output logic [31:0]              FlushCnt
`endif
);

  sb_entry_t  e_d, e_q, m_q, w_q;
  fwd_sel_e   fwd [NREAD];
  logic [NREAD-1:0] ld_hit;
  logic       ld_stall, pc_pend, pc_w, bubble_e;

  assign ld_stall = |ld_hit;
  assign bubble_e = ld_stall | BranchTakenE;
  assign pc_pend  = PCSrcD | (e_q.v & e_q.pc_src) | (m_q.v & m_q.pc_src);
  assign pc_w     = w_q.v & w_q.pc_src;

  always_comb begin
    e_d            = '0;
    e_d.v          = ~bubble_e;
    e_d.reg_write  = RegWriteD;
    e_d.mem_to_reg = MemtoRegD;
    e_d.pc_src     = PCSrcD;
    e_d.wa3        = WA3D;
    e_d.ra         = RAD;
    e_d.use_ra     = UseRAD;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q.v <= 1'b0;
      m_q.v <= 1'b0;
      w_q.v <= 1'b0;
    end else begin
      e_q <= e_d;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    haz_port_fwd #(.RADDR_W(RADDR_W), .PC_IDX(PC_IDX)) u_fwd (
      .ra_e_i   (e_q.ra[p]),
      .use_e_i  (e_q.v & e_q.use_ra[p]),
      .wr_m_i   (m_q.v & m_q.reg_write),
      .wa3_m_i  (m_q.wa3),
      .wr_w_i   (w_q.v & w_q.reg_write),
      .wa3_w_i  (w_q.wa3),
      .rad_i    (RAD[p*RADDR_W +: RADDR_W]),
      .use_d_i  (UseRAD[p]),
      .ld_e_i   (e_q.v & e_q.mem_to_reg),
      .wa3_e_i  (e_q.wa3),
      .fwd_o    (fwd[p]),
      .ld_hit_o (ld_hit[p])
    );
    assign ForwardE[2*p +: 2] = reset ? fwd[p] : FWD_RF;
  end

  // Outputs are forced low while reset is asserted, even for D-side inputs.
  assign StallF = reset & (ld_stall | pc_pend);
  assign StallD = reset & ld_stall;
  assign FlushD = reset & (pc_pend | pc_w | BranchTakenE);
  assign FlushE = reset & bubble_e;
  assign PCSrcW = reset & pc_w;

  logic unused_sb;
  assign unused_sb = ^{e_q.reg_write, m_q.mem_to_reg, m_q.ra, m_q.use_ra,
                       w_q.mem_to_reg, w_q.ra, w_q.use_ra};

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushE) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
